bitvec_encoder8to3: RTL and testbench

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per output handshake, lowest index first. It sits between request-vector producers (interrupt lines, one-hot selects) and index consumers, and flags empty and multi-hot vectors.

---
 rtl/bitvec_encoder8to3.sv | 88 ++++++++
 tb/tb_bitvec_encoder8to3.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bitvec_encoder8to3.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of
// every set bit, lowest first, one per output handshake.
module bitvec_encoder8to3 #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   out_cnt,
  output logic             out_onehot,
  output logic             empty_err
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_less_low;
  logic             found;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      c = c + {{IDX_W{1'b0}}, v[i]};
    return c;
  endfunction

  // Index and last flag are decoded from the pending register, so they
  // follow registered state only and reset with it.
  always_comb begin
    out_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && pending[i]) begin
        out_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  assign pending_less_low = pending & (pending - {{(WIDTH-1){1'b0}}, 1'b1});
  assign out_last  = (pending != '0) && (pending_less_low == '0);
  assign out_valid = (state == SERVE);
  assign in_ready  = rst_n && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      out_cnt    <= '0;
      out_onehot <= 1'b0;
      empty_err  <= 1'b0;
    end else begin
      empty_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_vec == '0) begin
              empty_err <= 1'b1;
            end else begin
              pending    <= in_vec;
              out_cnt    <= popcount(in_vec);
              out_onehot <= (popcount(in_vec) == {{IDX_W{1'b0}}, 1'b1});
              state      <= SERVE;
            end
          end
        end
        SERVE: begin
          if (out_ready) begin
            pending <= pending_less_low;
            if (out_last)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitvec_encoder8to3.sv
// Scoreboard bench for bitvec_encoder8to3: directed scenarios plus a sweep of
// all 256 vectors with random output backpressure.
module tb_bitvec_encoder8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_vec = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_idx;
  logic       out_last;
  logic [3:0] out_cnt;
  logic       out_onehot;
  logic       empty_err;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic [3:0] cnt;
    logic       onehot;
  } exp_t;

  exp_t sb[$];
  int   exp_empty = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  bitvec_encoder8to3 #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_cnt(out_cnt), .out_onehot(out_onehot),
    .empty_err(empty_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every index handshake is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("no_err_with_valid", {31'b0, empty_err & out_valid}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {23'b0, out_idx, out_last, out_cnt, out_onehot}, 32'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_tuple", {23'b0, out_idx, out_last, out_cnt, out_onehot}, {23'b0, e});
        end
      end
      if (empty_err) begin
        check("empty_err_expected", {31'b0, exp_empty > 0}, 32'd1);
        exp_empty--;
      end
    end
  end

  task automatic push_exp(input logic [7:0] v);
    int c;
    int seen;
    c = $countones(v);
    seen = 0;
    if (v == 8'h00) exp_empty++;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        exp_t e;
        seen++;
        e.idx = 3'(i);
        e.last = (seen == c);
        e.cnt = 4'(c);
        e.onehot = (c == 1);
        sb.push_back(e);
      end
    end
  endtask

  // Returns at one time unit after the accepting edge.
  task automatic send(input logic [7:0] v);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_vec = v;
    push_exp(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec = '0;
  endtask

  task automatic drain(input bit rand_ready);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid || exp_empty != 0) && t < 400) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    if (t >= 400) check("drain_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [2:0] a5_idx [4];
    a5_idx = '{3'd0, 3'd2, 3'd5, 3'd7};

    // Reset state
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_outs", {23'b0, out_idx, out_last, out_cnt, out_onehot}, 32'd0);
    check("rst_empty_err", {31'b0, empty_err}, 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Single bit
    out_ready = 1'b1;
    send(8'h10);
    check("h10_valid", {31'b0, out_valid}, 32'd1);
    check("h10_tuple", {23'b0, out_idx, out_last, out_cnt, out_onehot}, {23'b0, 3'd4, 1'b1, 4'd1, 1'b1});
    @(posedge clk); #1;
    check("h10_done_valid", {31'b0, out_valid}, 32'd0);
    check("h10_done_ready", {31'b0, in_ready}, 32'd1);

    // Four bits back to back
    send(8'hA5);
    for (int k = 0; k < 4; k++) begin
      check("a5_valid", {31'b0, out_valid}, 32'd1);
      check("a5_idx", {29'b0, out_idx}, {29'b0, a5_idx[k]});
      check("a5_last", {31'b0, out_last}, {31'b0, k == 3});
      check("a5_cnt", {28'b0, out_cnt}, 32'd4);
      check("a5_onehot", {31'b0, out_onehot}, 32'd0);
      @(posedge clk); #1;
    end
    check("a5_done", {31'b0, out_valid}, 32'd0);

    // Backpressure, with a vector offered while busy
    out_ready = 1'b0;
    send(8'h81);
    in_valid = 1'b1;
    in_vec = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_tuple", {23'b0, out_valid, out_idx, out_last, out_cnt}, {23'b0, 1'b1, 3'd0, 1'b0, 4'd2});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_vec = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idx7", {23'b0, out_valid, out_idx, out_last}, {23'b0, 1'b1, 3'd7, 1'b1});
    @(posedge clk); #1;
    check("bp_done", {31'b0, out_valid}, 32'd0);

    // Empty vector
    send(8'h00);
    check("empty_pulse", {31'b0, empty_err}, 32'd1);
    check("empty_no_valid", {31'b0, out_valid}, 32'd0);
    check("empty_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("empty_pulse_end", {31'b0, empty_err}, 32'd0);
    send(8'h80);
    check("h80_tuple", {23'b0, out_valid, out_idx, out_last}, {23'b0, 1'b1, 3'd7, 1'b1});
    drain(1'b0);

    // Reset mid-vector
    send(8'hFF);
    check("ff_cnt", {28'b0, out_cnt}, 32'd8);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("midrst_outs", {23'b0, out_idx, out_last, out_cnt, out_onehot}, 32'd0);
    check("midrst_sb_left", sb.size(), 32'd6);
    sb.delete();
    #10 rst_n = 1'b1;
    #1;
    check("postrst_ready", {31'b0, in_ready}, 32'd1);
    send(8'h02);
    check("h02_tuple", {23'b0, out_idx, out_last, out_cnt}, {23'b0, 3'd1, 1'b1, 4'd1});
    drain(1'b0);

    // Full sweep with random backpressure
    for (int v = 0; v < 256; v++) begin
      send(8'(v));
      drain(1'b1);
    end

    check("sb_empty_end", sb.size(), 32'd0);
    check("empty_count_end", exp_empty, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
